// File: rtl/keypad_alarm_ctrl_if.sv
// ----------------------------------------------------------------------------
// keypad_alarm_ctrl_if
//   Pin-level bundle between the keypad/sensor side and keypad_alarm_ctrl.
//
//   Signals (direction as seen by the controller, modport slave):
//     row               in   4        keypad rows, row[3] = row 1
//     is_breach         in   1        security sensor level
//     col               out  4        one-hot column drive, col[3] = col 1
//     key_valid         out  1        1-cycle strobe, debounced key accepted
//     key_code          out  4        {row_idx,col_idx}, qualified by key_valid
//     digit_count       out  DCW      digits currently buffered
//     is_enabled        out  1        system armed
//     led               out  1        copy of is_enabled
//     alert_authorities out  1        high in ALARM
//     locked_out        out  1        high while the lockout timer runs
//     dbg_scan_state    out  2        scanner state (0 SCAN, 1 DEBOUNCE, 2 RELEASE)
//     dbg_alarm_state   out  3        alarm state (0 DISARMED, 1 ARMED,
//                                     2 ENTRY_DELAY, 3 ALARM, 4 PROGRAM)
//
//   Handshake: there is no backpressure anywhere in this bundle. key_valid is
//   a one-cycle strobe and key_code is meaningful only in that cycle; every
//   other output is a level that may be sampled at any time away from the
//   rising clock edge.
//
//   modport master : the keypad/sensor side (drives row, is_breach)
//   modport slave  : the controller
// ----------------------------------------------------------------------------
interface keypad_alarm_ctrl_if #(
  parameter int CODE_LEN = 4
) ();
  localparam int DCW = $clog2(CODE_LEN + 1);

  logic [3:0]     row;
  logic           is_breach;
  logic [3:0]     col;
  logic           key_valid;
  logic [3:0]     key_code;
  logic [DCW-1:0] digit_count;
  logic           is_enabled;
  logic           led;
  logic           alert_authorities;
  logic           locked_out;
  logic [1:0]     dbg_scan_state;
  logic [2:0]     dbg_alarm_state;

  modport master (
    output row, is_breach,
    input  col, key_valid, key_code, digit_count, is_enabled, led,
           alert_authorities, locked_out, dbg_scan_state, dbg_alarm_state
  );

  modport slave (
    input  row, is_breach,
    output col, key_valid, key_code, digit_count, is_enabled, led,
           alert_authorities, locked_out, dbg_scan_state, dbg_alarm_state
  );
endinterface

// File: rtl/keypad_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// keypad_alarm_ctrl
//   4x4 matrix-keypad security controller. Scans the columns, debounces the
//   rows, collects CODE_LEN-digit codes and arms/disarms the system. Wrong
//   codes are counted; MAX_FAIL consecutive failures lock the keypad for
//   LOCKOUT_CYC cycles. A breach while armed starts an entry delay of
//   ENTRY_DELAY_CYC cycles before the authority alert is raised. Key '*'
//   (code 4'b1100) clears the digit buffer.
//
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  keypad_alarm_ctrl_if.slave (row, is_breach in; col, key_valid,
//          key_code, digit_count, is_enabled, led, alert_authorities,
//          locked_out and the two debug state fields out)
//
//   Build option: define KEYPAD_CODE_CHANGE_EN to allow changing the code.
//   Key 'D' (4'b1111) pressed in DISARMED with an empty buffer (and not
//   locked out) enters PROGRAM; the next CODE_LEN digits become the stored
//   code. '*' aborts PROGRAM. Without the macro 'D' is an ordinary digit and
//   the code is fixed at DEFAULT_CODE.
// ----------------------------------------------------------------------------
module keypad_alarm_ctrl #(
  parameter int                    CODE_LEN        = 4,
  parameter int                    DEBOUNCE_CYC    = 4,
  parameter int                    MAX_FAIL        = 3,
  parameter int                    LOCKOUT_CYC     = 1000,
  parameter int                    ENTRY_DELAY_CYC = 500,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE    = 16'h0965
) (
  input  logic                clk,
  input  logic                rst,
  keypad_alarm_ctrl_if.slave  bus
);

  localparam int DCW         = $clog2(CODE_LEN + 1);
  localparam int DBW         = $clog2(DEBOUNCE_CYC + 1);
  localparam int FCW         = $clog2(MAX_FAIL + 1);
  localparam int LOCK_LOAD   = (LOCKOUT_CYC < 1) ? 1 : LOCKOUT_CYC;
  localparam int LKW         = $clog2(LOCK_LOAD + 1);
  localparam int ENTRY_LOAD  = (ENTRY_DELAY_CYC < 1) ? 1 : ENTRY_DELAY_CYC;
  localparam int EDW         = $clog2(ENTRY_LOAD + 1);

  localparam logic [3:0] KEY_CLEAR = 4'b1100;
`ifdef KEYPAD_CODE_CHANGE_EN
  localparam logic [3:0] KEY_PROG  = 4'b1111;
`endif

  typedef enum logic [1:0] {
    SC_SCAN     = 2'd0,
    SC_DEBOUNCE = 2'd1,
    SC_RELEASE  = 2'd2
  } scan_e;

  typedef enum logic [2:0] {
    AL_DISARMED = 3'd0,
    AL_ARMED    = 3'd1,
    AL_ENTRY    = 3'd2,
    AL_ALARM    = 3'd3,
    AL_PROGRAM  = 3'd4
  } alarm_e;

  // Row/column one-hot mask to index; bit 3 is row/column 1 (index 0).
  function automatic logic [1:0] enc(input logic [3:0] m);
    logic [1:0] idx;
    if (m[3])      idx = 2'd0;
    else if (m[2]) idx = 2'd1;
    else if (m[1]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  // ---------------------------------------------------------------- scanner
  scan_e          scan_q;
  logic [3:0]     col_q;
  logic [3:0]     row_q;
  logic [DBW-1:0] db_cnt_q;
  logic           key_valid_q;
  logic [3:0]     key_code_q;

  logic           row_zero;
  logic           row_onehot;
  logic [DBW-1:0] stable_d;

  // stable_d is the length of the current run of identical one-hot row
  // samples, including this cycle. A run starts fresh on entry from SCAN.
  always_comb begin
    row_zero   = (bus.row == 4'b0000);
    row_onehot = !row_zero && ((bus.row & (bus.row - 4'd1)) == 4'b0000);
    stable_d   = '0;
    if (row_onehot) begin
      if (scan_q == SC_DEBOUNCE && bus.row == row_q) stable_d = db_cnt_q + 1'b1;
      else                                          stable_d = DBW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q      <= SC_SCAN;
      col_q       <= 4'b1000;
      row_q       <= 4'b0000;
      db_cnt_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'b0000;
    end else begin
      key_valid_q <= 1'b0;
      unique case (scan_q)
        SC_SCAN, SC_DEBOUNCE: begin
          if (row_zero) begin
            // Only an idle scanner advances; a bounce that dies out just
            // returns to scanning from the frozen column.
            if (scan_q == SC_SCAN) col_q <= {col_q[0], col_q[3:1]};
            scan_q   <= SC_SCAN;
            db_cnt_q <= '0;
          end else if (stable_d == DBW'(DEBOUNCE_CYC)) begin
            key_valid_q <= 1'b1;
            key_code_q  <= {enc(bus.row), enc(col_q)};
            scan_q      <= SC_RELEASE;
            db_cnt_q    <= '0;
          end else begin
            row_q    <= bus.row;
            db_cnt_q <= stable_d;
            scan_q   <= SC_DEBOUNCE;
          end
        end
        SC_RELEASE: begin
          if (!row_zero) begin
            db_cnt_q <= '0;
          end else if (db_cnt_q == DBW'(DEBOUNCE_CYC - 1)) begin
            scan_q   <= SC_SCAN;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: begin
          scan_q   <= SC_SCAN;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------- code and alarm
  alarm_e                alarm_q;
  logic [3:0]            buf_q [CODE_LEN];
  logic [DCW-1:0]        dc_q;
  logic                  code_done_q;
  logic                  code_ok_q;
  logic [FCW-1:0]        fail_q;
  logic                  locked_q;
  logic [LKW-1:0]        lock_tmr_q;
  logic [EDW-1:0]        entry_tmr_q;
  logic                  is_enabled_q;
  logic                  alert_q;
  logic [CODE_LEN*4-1:0] entered;
  logic                  code_match;

`ifdef KEYPAD_CODE_CHANGE_EN
  logic [CODE_LEN*4-1:0] code_q;
`endif

  // Full code as it would stand with the key now being accepted as the last
  // digit; first digit lands in the most significant nibble.
  always_comb begin
    entered = '0;
    for (int i = 0; i < CODE_LEN - 1; i++) entered[(CODE_LEN-1-i)*4 +: 4] = buf_q[i];
    entered[3:0] = key_code_q;
  end

  // The verdict is registered one cycle after the last digit so that the
  // comparator sits alone in its own cycle; disarm beats breach/expiry.
  assign code_match = code_done_q && code_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q      <= AL_DISARMED;
      for (int i = 0; i < CODE_LEN; i++) buf_q[i] <= 4'b0000;
      dc_q         <= '0;
      code_done_q  <= 1'b0;
      code_ok_q    <= 1'b0;
      fail_q       <= '0;
      locked_q     <= 1'b0;
      lock_tmr_q   <= '0;
      entry_tmr_q  <= '0;
      is_enabled_q <= 1'b0;
      alert_q      <= 1'b0;
`ifdef KEYPAD_CODE_CHANGE_EN
      code_q       <= DEFAULT_CODE;
`endif
    end else begin
      code_done_q <= 1'b0;

      if (locked_q) begin
        if (lock_tmr_q == LKW'(1)) begin
          locked_q <= 1'b0;
          fail_q   <= '0;
        end else begin
          lock_tmr_q <= lock_tmr_q - 1'b1;
        end
      end

      if (code_done_q) begin
        if (code_ok_q) begin
          fail_q <= '0;
        end else if (fail_q == FCW'(MAX_FAIL - 1)) begin
          fail_q     <= fail_q + 1'b1;
          locked_q   <= 1'b1;
          lock_tmr_q <= LKW'(LOCK_LOAD);
        end else begin
          fail_q <= fail_q + 1'b1;
        end
      end

      unique case (alarm_q)
        AL_DISARMED: begin
          // Breach is not looked at here, so a breach in the arming cycle
          // is only seen from the following cycle on.
          if (code_match) begin
            alarm_q      <= AL_ARMED;
            is_enabled_q <= 1'b1;
          end
        end
        AL_ARMED: begin
          if (code_match) begin
            alarm_q      <= AL_DISARMED;
            is_enabled_q <= 1'b0;
            alert_q      <= 1'b0;
          end else if (bus.is_breach) begin
            alarm_q     <= AL_ENTRY;
            entry_tmr_q <= EDW'(ENTRY_LOAD);
          end
        end
        AL_ENTRY: begin
          if (code_match) begin
            alarm_q      <= AL_DISARMED;
            is_enabled_q <= 1'b0;
            alert_q      <= 1'b0;
          end else if (entry_tmr_q == EDW'(1)) begin
            alarm_q <= AL_ALARM;
            alert_q <= 1'b1;
          end else begin
            entry_tmr_q <= entry_tmr_q - 1'b1;
          end
        end
        AL_ALARM: begin
          if (code_match) begin
            alarm_q      <= AL_DISARMED;
            is_enabled_q <= 1'b0;
            alert_q      <= 1'b0;
          end
        end
        default: begin
          // PROGRAM leaves only through the key path below.
        end
      endcase

      // Keys arriving during lockout still strobe key_valid but are dropped.
      if (key_valid_q && !locked_q) begin
        if (key_code_q == KEY_CLEAR) begin
          dc_q <= '0;
`ifdef KEYPAD_CODE_CHANGE_EN
          if (alarm_q == AL_PROGRAM) alarm_q <= AL_DISARMED;
`endif
        end
`ifdef KEYPAD_CODE_CHANGE_EN
        else if (key_code_q == KEY_PROG && alarm_q == AL_DISARMED && dc_q == '0) begin
          alarm_q <= AL_PROGRAM;
        end
`endif
        else if (dc_q == DCW'(CODE_LEN - 1)) begin
          dc_q <= '0;
`ifdef KEYPAD_CODE_CHANGE_EN
          if (alarm_q == AL_PROGRAM) begin
            code_q  <= entered;
            alarm_q <= AL_DISARMED;
          end else begin
            code_done_q <= 1'b1;
            code_ok_q   <= (entered == code_q);
          end
`else
          code_done_q <= 1'b1;
          code_ok_q   <= (entered == DEFAULT_CODE);
`endif
        end else begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (dc_q == DCW'(i)) buf_q[i] <= key_code_q;
          end
          dc_q <= dc_q + 1'b1;
        end
      end
    end
  end

  assign bus.col               = col_q;
  assign bus.key_valid         = key_valid_q;
  assign bus.key_code          = key_code_q;
  assign bus.digit_count       = dc_q;
  assign bus.is_enabled        = is_enabled_q;
  assign bus.led               = is_enabled_q;
  assign bus.alert_authorities = alert_q;
  assign bus.locked_out        = locked_q;
  assign bus.dbg_scan_state    = scan_q;
  assign bus.dbg_alarm_state   = alarm_q;

endmodule

// File: tb/tb_keypad_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_keypad_alarm_ctrl
//   Directed bench for keypad_alarm_ctrl with DEBOUNCE_CYC=2, MAX_FAIL=3,
//   LOCKOUT_CYC=20, ENTRY_DELAY_CYC=10. A table of key presses with the
//   expected digit count / arm / lockout state after each press, followed by
//   hand-written sequences for debounce, breach timing, lockout, code change
//   (when KEYPAD_CODE_CHANGE_EN is defined) and reset mid-entry. Every
//   key_valid strobe is matched against an expected key code queue.
// ----------------------------------------------------------------------------
module tb_keypad_alarm_ctrl;
  localparam int CODE_LEN = 4;

  // ------------------------------------------------- clock / reset / DUT
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_alarm_ctrl_if #(.CODE_LEN(CODE_LEN)) ifc ();

  keypad_alarm_ctrl #(
    .CODE_LEN       (CODE_LEN),
    .DEBOUNCE_CYC   (2),
    .MAX_FAIL       (3),
    .LOCKOUT_CYC    (20),
    .ENTRY_DELAY_CYC(10),
    .DEFAULT_CODE   (16'h0965)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  // ------------------------------------------------------------ scoreboard
  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int lock_cycles = 0;
  logic [3:0] exp_q[$];
  logic [15:0] cur_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every key_valid strobe must match the next expected key code.
  always @(negedge clk) begin
    if (ifc.locked_out) lock_cycles++;
    if (ifc.key_valid) begin
      kv_cnt++;
      if (exp_q.size() == 0) chk("kv_unexpected", 32'(ifc.key_code), 32'hffff_ffff);
      else                   chk("kv_code", 32'(ifc.key_code), 32'(exp_q.pop_front()));
    end
  end

  // ------------------------------------------------------------- drivers
  // Press key kc (= {row_idx,col_idx}) as a real keypad would: the row only
  // reads back while its column is driven. Callers start on a falling edge.
  task automatic press(input logic [3:0] kc);
    logic [3:0] rm;
    logic [3:0] cm;
    int n;
    rm = 4'b1000 >> kc[3:2];
    cm = 4'b1000 >> kc[1:0];
    exp_q.push_back(kc);
    n = 0;
    while (ifc.col !== cm && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (ifc.col !== cm) chk("col_wait", 32'(ifc.col), 32'(cm));
    ifc.row = rm;
    repeat (5) @(negedge clk);
    ifc.row = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [3:0] key;
    logic [2:0] exp_dc;
    logic       exp_en;
    logic       exp_lock;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] k, input logic [2:0] dc, input logic en);
    vec_t v;
    v.key = k; v.exp_dc = dc; v.exp_en = en; v.exp_lock = 1'b0;
    tbl.push_back(v);
  endfunction

  // ---------------------------------------------------------------- test
  initial begin
    int kv0;
    int n;

    // 1865 arms, 1865 disarms, clear mid-entry, wrong code while armed
    // leaves it armed, 1865 disarms, clear on an empty buffer.
    add(4'h0, 3'd1, 1'b0); add(4'h9, 3'd2, 1'b0); add(4'h6, 3'd3, 1'b0); add(4'h5, 3'd0, 1'b1);
    add(4'h0, 3'd1, 1'b1); add(4'h9, 3'd2, 1'b1); add(4'h6, 3'd3, 1'b1); add(4'h5, 3'd0, 1'b0);
    add(4'h0, 3'd1, 1'b0); add(4'h9, 3'd2, 1'b0); add(4'hC, 3'd0, 1'b0);
    add(4'h0, 3'd1, 1'b0); add(4'h9, 3'd2, 1'b0); add(4'h6, 3'd3, 1'b0); add(4'h5, 3'd0, 1'b1);
    add(4'hF, 3'd1, 1'b1); add(4'h0, 3'd2, 1'b1); add(4'h0, 3'd3, 1'b1); add(4'h0, 3'd0, 1'b1);
    add(4'h0, 3'd1, 1'b1); add(4'h9, 3'd2, 1'b1); add(4'h6, 3'd3, 1'b1); add(4'h5, 3'd0, 1'b0);
    add(4'hC, 3'd0, 1'b0);

    cur_code = 16'h0965;
    rst = 1'b1;
    ifc.row = 4'b0000;
    ifc.is_breach = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(ifc.col), 32'h8);
    chk("rst_kv", 32'(ifc.key_valid), 32'h0);
    chk("rst_code", 32'(ifc.key_code), 32'h0);
    chk("rst_dc", 32'(ifc.digit_count), 32'h0);
    chk("rst_en", 32'(ifc.is_enabled), 32'h0);
    chk("rst_led", 32'(ifc.led), 32'h0);
    chk("rst_alert", 32'(ifc.alert_authorities), 32'h0);
    chk("rst_lock", 32'(ifc.locked_out), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_rotate", 32'(ifc.col), 32'h4);

    // Table-driven presses
    for (int i = 0; i < tbl.size(); i++) begin
      kv0 = kv_cnt;
      press(tbl[i].key);
      chk($sformatf("t%0d_kvcount", i), 32'(kv_cnt - kv0), 32'd1);
      chk($sformatf("t%0d_dc", i), 32'(ifc.digit_count), 32'(tbl[i].exp_dc));
      chk($sformatf("t%0d_en", i), 32'(ifc.is_enabled), 32'(tbl[i].exp_en));
      chk($sformatf("t%0d_led", i), 32'(ifc.led), 32'(tbl[i].exp_en));
      chk($sformatf("t%0d_lock", i), 32'(ifc.locked_out), 32'(tbl[i].exp_lock));
    end

    // One-cycle row glitch: no key
    kv0 = kv_cnt;
    ifc.row = 4'b0100;
    @(negedge clk);
    ifc.row = 4'b0000;
    repeat (6) @(negedge clk);
    chk("glitch_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("glitch_scan", 32'(ifc.dbg_scan_state), 32'd0);

    // Two rows at once held 5 cycles: held in debounce, no key, scan resumes
    ifc.row = 4'b1100;
    repeat (5) @(negedge clk);
    chk("multi_hold_state", 32'(ifc.dbg_scan_state), 32'd1);
    ifc.row = 4'b0000;
    repeat (4) @(negedge clk);
    chk("multi_kv", 32'(kv_cnt - kv0), 32'd0);
    chk("multi_scan", 32'(ifc.dbg_scan_state), 32'd0);
    chk("multi_dc", 32'(ifc.digit_count), 32'd0);

    // Breach ignored while disarmed
    ifc.is_breach = 1'b1;
    repeat (15) @(negedge clk);
    ifc.is_breach = 1'b0;
    chk("dis_breach_alert", 32'(ifc.alert_authorities), 32'd0);
    chk("dis_breach_state", 32'(ifc.dbg_alarm_state), 32'd0);

    // Armed: 1-cycle breach pulse, alert exactly 10 cycles later
    enter_code(cur_code);
    chk("arm_en", 32'(ifc.is_enabled), 32'd1);
    ifc.is_breach = 1'b1;
    @(negedge clk);
    ifc.is_breach = 1'b0;
    repeat (9) @(negedge clk);
    chk("entry_state", 32'(ifc.dbg_alarm_state), 32'd2);
    chk("entry_alert_early", 32'(ifc.alert_authorities), 32'd0);
    @(negedge clk);
    chk("entry_alert_on", 32'(ifc.alert_authorities), 32'd1);
    chk("alarm_en", 32'(ifc.is_enabled), 32'd1);
    enter_code(cur_code);
    chk("alarm_clear_alert", 32'(ifc.alert_authorities), 32'd0);
    chk("alarm_clear_en", 32'(ifc.is_enabled), 32'd0);

    // Three wrong codes lock the keypad for 20 cycles
    lock_cycles = 0;
    enter_code(16'h0000);
    chk("fail1_lock", 32'(ifc.locked_out), 32'd0);
    enter_code(16'h0000);
    chk("fail2_lock", 32'(ifc.locked_out), 32'd0);
    enter_code(16'h0000);
    chk("fail3_lock", 32'(ifc.locked_out), 32'd1);
    kv0 = kv_cnt;
    press(4'h0);
    chk("lock_kv_pulses", 32'(kv_cnt - kv0), 32'd1);
    chk("lock_key_dropped", 32'(ifc.digit_count), 32'd0);
    n = 0;
    while (ifc.locked_out && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("lock_release", 32'(ifc.locked_out), 32'd0);
    chk("lock_duration", 32'(lock_cycles), 32'd20);
    enter_code(cur_code);
    chk("after_lock_arm", 32'(ifc.is_enabled), 32'd1);
    enter_code(cur_code);
    chk("after_lock_disarm", 32'(ifc.is_enabled), 32'd0);

`ifdef KEYPAD_CODE_CHANGE_EN
    // D,1,2,3,4 programs code {0,1,2,4}
    press(4'hF);
    chk("prog_enter", 32'(ifc.dbg_alarm_state), 32'd4);
    chk("prog_dc", 32'(ifc.digit_count), 32'd0);
    enter_code(16'h0124);
    chk("prog_exit", 32'(ifc.dbg_alarm_state), 32'd0);
    chk("prog_en", 32'(ifc.is_enabled), 32'd0);
    enter_code(16'h0965);
    chk("prog_old_code", 32'(ifc.is_enabled), 32'd0);
    enter_code(16'h0124);
    chk("prog_new_arm", 32'(ifc.is_enabled), 32'd1);
    enter_code(16'h0124);
    chk("prog_new_disarm", 32'(ifc.is_enabled), 32'd0);
    cur_code = 16'h0124;
`endif

    // Reset mid-entry while armed
    enter_code(cur_code);
    chk("pre_rst_en", 32'(ifc.is_enabled), 32'd1);
    press(4'h0);
    press(4'h9);
    chk("pre_rst_dc", 32'(ifc.digit_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dc", 32'(ifc.digit_count), 32'd0);
    chk("mid_rst_en", 32'(ifc.is_enabled), 32'd0);
    chk("mid_rst_led", 32'(ifc.led), 32'd0);
    chk("mid_rst_col", 32'(ifc.col), 32'h8);
    chk("mid_rst_code", 32'(ifc.key_code), 32'h0);
    chk("mid_rst_alert", 32'(ifc.alert_authorities), 32'd0);
    chk("mid_rst_lock", 32'(ifc.locked_out), 32'd0);
    rst = 1'b0;
    cur_code = 16'h0965;
    @(negedge clk);
    enter_code(cur_code);
    chk("post_rst_arm", 32'(ifc.is_enabled), 32'd1);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
